// File: rtl/key_serial_reader_if.sv
// Host/key-side signal bundle for key_serial_reader.
// The match signal exists only when KEY_SERIAL_READER_CHECK_EN is defined.
interface key_serial_reader_if #(
  parameter int unsigned WORD_BITS = 16
);
  logic                 start;
  logic                 SDRD;
  logic                 SSER;
  logic                 BA13;
  logic                 BA12;
  logic [3:0]           BA;
  logic                 BR_W;
  logic                 busy;
  logic                 done;
  logic [WORD_BITS-1:0] data;
`ifdef KEY_SERIAL_READER_CHECK_EN
  logic                 match;

  modport master (
    input  start, SDRD,
    output SSER, BA13, BA12, BA, BR_W, busy, done, data, match
  );

  modport slave (
    output start, SDRD,
    input  SSER, BA13, BA12, BA, BR_W, busy, done, data, match
  );
`else
  modport master (
    input  start, SDRD,
    output SSER, BA13, BA12, BA, BR_W, busy, done, data
  );

  modport slave (
    output start, SDRD,
    input  SSER, BA13, BA12, BA, BR_W, busy, done, data
  );
`endif
endinterface

// File: rtl/key_serial_reader.sv
// Serial key window initiator: unlock reads, then WORD_BITS serial data reads assembled MSB-first.
// Optional word comparator and match output enabled by KEY_SERIAL_READER_CHECK_EN.
module key_serial_reader #(
  parameter int unsigned WORD_BITS  = 16,
  parameter int unsigned UNLOCK_LEN = 4,
  parameter logic [31:0] UNLOCK_SEQ = 32'h0000_A5C9,
  parameter logic [3:0]  READ_NIB   = 4'h0,
  parameter int unsigned ACC_CYC    = 2
`ifdef KEY_SERIAL_READER_CHECK_EN
  ,
  parameter logic [WORD_BITS-1:0] EXPECT = '1
`endif
) (
  input logic                 clk,
  input logic                 rst,
  key_serial_reader_if.master bus_io
);

  localparam int unsigned MaxAcc = (UNLOCK_LEN > WORD_BITS) ? UNLOCK_LEN : WORD_BITS;
  localparam int unsigned AccW   = $clog2(MaxAcc);
  localparam int unsigned CycW   = $clog2(ACC_CYC);

  localparam logic [AccW-1:0] UnlockLast = AccW'(UNLOCK_LEN - 1);
  localparam logic [AccW-1:0] ReadLast   = AccW'(WORD_BITS - 1);
  localparam logic [CycW-1:0] CycLast    = CycW'(ACC_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StUnlock,
    StGap,
    StRead,
    StDone
  } state_e;

  state_e               state_q;
  logic [AccW-1:0]      acc_q;
  logic [CycW-1:0]      cyc_q;
  logic                 read_phase_q;
  logic [WORD_BITS-1:0] shift_q;
  logic                 sser_q;
  logic                 ba12_q;
  logic [3:0]           ba_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WORD_BITS-1:0] data_q;
`ifdef KEY_SERIAL_READER_CHECK_EN
  logic                 match_q;
`endif

  function automatic logic [3:0] unlock_nib(input logic [AccW-1:0] k);
    logic [31:0] sh;
    sh = UNLOCK_SEQ >> {k, 2'b00};
    return sh[3:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      cyc_q        <= '0;
      read_phase_q <= 1'b0;
      shift_q      <= '0;
      sser_q       <= 1'b1;
      ba12_q       <= 1'b0;
      ba_q         <= 4'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
`ifdef KEY_SERIAL_READER_CHECK_EN
      match_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q      <= StUnlock;
            acc_q        <= '0;
            cyc_q        <= '0;
            read_phase_q <= 1'b0;
            shift_q      <= '0;
            sser_q       <= 1'b0;
            ba12_q       <= 1'b1;
            ba_q         <= unlock_nib('0);
            busy_q       <= 1'b1;
          end
        end
        StUnlock, StRead: begin
          if (cyc_q == CycLast) begin
            sser_q  <= 1'b1;
            state_q <= StGap;
            if (state_q == StRead) begin
              shift_q <= {shift_q[WORD_BITS-2:0], bus_io.SDRD};
            end
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        StGap: begin
          cyc_q <= '0;
          if (read_phase_q) begin
            if (acc_q == ReadLast) begin
              // Trailing gap of the last read hands over straight to the result clock.
              state_q <= StDone;
              sser_q  <= 1'b1;
              ba12_q  <= 1'b0;
              ba_q    <= 4'h0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              data_q  <= shift_q;
`ifdef KEY_SERIAL_READER_CHECK_EN
              match_q <= (shift_q == EXPECT);
`endif
            end else begin
              state_q <= StRead;
              acc_q   <= acc_q + AccW'(1);
              sser_q  <= 1'b0;
            end
          end else if (acc_q == UnlockLast) begin
            state_q      <= StRead;
            acc_q        <= '0;
            read_phase_q <= 1'b1;
            sser_q       <= 1'b0;
            ba_q         <= READ_NIB;
          end else begin
            state_q <= StUnlock;
            acc_q   <= acc_q + AccW'(1);
            sser_q  <= 1'b0;
            ba_q    <= unlock_nib(acc_q + AccW'(1));
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.SSER = sser_q;
  assign bus_io.BA13 = 1'b0;
  assign bus_io.BA12 = ba12_q;
  assign bus_io.BA   = ba_q;
  assign bus_io.BR_W = 1'b1;
  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.data = data_q;
`ifdef KEY_SERIAL_READER_CHECK_EN
  assign bus_io.match = match_q;
`endif

endmodule

// File: doc/key_serial_reader.md
Name: key_serial_reader

Overview:
- Bus-side initiator for the serial key window.
- Issues the unlock read sequence, then clocks out a serial bit stream one read at a time.
- Samples the key's serial data line on each read and assembles the bits into a parallel word for the host controller.
- Sits between the host control logic and the key socket; it drives the select, address and direction lines the key decodes.

Parameters:
- WORD_BITS, 16: number of serial bits read per transaction (2..32).
- UNLOCK_LEN, 4: number of unlock reads issued before data reads (1..8).
- UNLOCK_SEQ, 32'h0000_A5C9: unlock address nibbles (BA7..BA4), 4 bits per read. Nibble 0 (bits 3:0) is issued first.
- READ_NIB, 4'h0: BA7..BA4 value used for data reads.
- ACC_CYC, 2: clocks per bus access, select low (2..8).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; accepted only while busy=0.
- SDRD  in  1  serial data from key; sampled on the last clock of each data access.
- SSER  out  1  key select, active low.
- BA13  out  1  window select; constant 0 during accesses, 0 at idle.
- BA12  out  1  window select; 1 during accesses, 0 at idle.
- BA  out  4  address nibble BA7..BA4.
- BR_W  out  1  direction; always 1 (read) during accesses, 1 at idle.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when data is valid.
- data  out  WORD_BITS  assembled word; holds last result until next done.

Behaviour:
- Reset values: SSER=1, BA13=0, BA12=0, BA=0, BR_W=1, busy=0, done=0, data=0. FSM=IDLE, counters=0.
- Reset is synchronous: asserting rst mid-transaction returns to IDLE on the next edge, releases SSER=1 and discards partial data.
- States:
  - IDLE: waits for start; start while busy=1 is ignored.
  - UNLOCK: issues UNLOCK_LEN accesses with BA = UNLOCK_SEQ nibble k, k=0..UNLOCK_LEN-1. SDRD is ignored.
  - GAP: one clock with SSER=1 between every two accesses, including UNLOCK->READ.
  - READ: issues WORD_BITS accesses with BA=READ_NIB.
  - DONE: one clock; done=1 and data updated; then IDLE.
- Access timing:
  - SSER low for exactly ACC_CYC consecutive clocks.
  - BA, BA12 and BR_W are stable from the first clock of SSER low through the following GAP clock.
  - SDRD is sampled in the last SSER-low clock.
- Bit order: first sampled bit becomes data[WORD_BITS-1], last becomes data[0]. The shift register is internal; data updates only in DONE.
- busy goes 1 the clock after start is accepted and 0 in the DONE clock. A start in the DONE clock is ignored; start is accepted again from the following clock.
- Latency, start accepted to done: UNLOCK_LEN*(ACC_CYC+1) + WORD_BITS*(ACC_CYC+1) + 1 clocks. With defaults: 4*3+16*3+1=61.
- Counters saturate-free: the access counter is wide enough for max(UNLOCK_LEN,WORD_BITS). The cycle counter is wide enough for ACC_CYC; it reloads at each GAP.

Optional Feature:
- Macro KEY_SERIAL_READER_CHECK_EN. When defined, adds:
  - parameter EXPECT (WORD_BITS wide, default all ones).
  - output match (1 bit, reset 0), updated in DONE together with data: 1 iff the assembled word == EXPECT, held until next DONE.
- Without the macro, neither the port nor the comparator exists and behaviour is otherwise identical.

Test Plan:
- Reset idle: hold rst 3 clocks -> SSER=1, BA12=0, busy=0, done=0, data=0. No accesses while start=0 for 50 clocks.
- Unlock sequence: defaults, pulse start -> four 2-clock SSER-low windows with BA=9, C, 5, A in order, each separated by a 1-clock SSER=1 gap.
- Data assembly: SDRD model drives 16'hB38E MSB-first on each data access -> done at clock 61 after start, data=16'hB38E, busy low same clock.
- Start while busy: pulse start at clocks 10 and 40 of a transaction -> exactly one transaction, done pulses once. A start in the DONE clock is ignored.
- Reset mid-read: assert rst during the 5th data access -> next clock SSER=1, busy=0. A new start yields a full, correct 61-clock transaction.
- CHECK_EN: EXPECT=16'hB38E, read 16'hB38E -> match=1. Next read of 16'hB38F -> match=0 at its done.
